// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder/subtractor cell with a registered
// carry/borrow, processing WIDTH bits LSB first behind a start/busy/done handshake.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_cy;
  logic             r_op;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;

  logic             w_bit;
  logic             w_cy_next;
  logic [WIDTH-1:0] w_sr_next;

  function automatic logic cell_bit(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  // Carry for add is the majority; borrow for subtract follows the full-subtractor form.
  function automatic logic cell_carry(input logic sub, input logic x, input logic y,
                                      input logic c);
    if (sub)
      return (~x & y) | (~(x ^ y) & c);
    else
      return (x & y) | (x & c) | (y & c);
  endfunction

  function automatic logic ovf_flag(input logic sub, input logic a_msb, input logic b_msb,
                                    input logic r_msb);
    if (sub)
      return (a_msb != b_msb) && (r_msb != a_msb);
    else
      return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  assign w_bit     = cell_bit(r_sa[0], r_sb[0], r_cy);
  assign w_cy_next = cell_carry(r_op, r_sa[0], r_sb[0], r_cy);
  assign w_sr_next = {w_bit, r_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_sa     <= '0;
      r_sb     <= '0;
      r_sr     <= '0;
      r_cy     <= 1'b0;
      r_op     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_op    <= op;
            r_cy    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_sr  <= w_sr_next;
          r_cy  <= w_cy_next;
          r_cnt <= r_cnt + 1'b1;
          // On the last bit sa[0]/sb[0] hold the operand MSBs, so flags resolve here.
          if (r_cnt == LAST) begin
            r_result <= w_sr_next;
            r_cout   <= w_cy_next;
            r_ovf    <= ovf_flag(r_op, r_sa[0], r_sb[0], w_bit);
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: table vectors and random operands through a scoreboard,
// plus hand-written sequences for ignored start, mid-run reset and back-to-back issue.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } vec_t;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W:0] s;
    if (o) begin
      s   = {1'b0, x} - {1'b0, y};
      e.r = s[W-1:0];
      e.c = (x < y);
      e.v = (x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]);
    end else begin
      s   = {1'b0, x} + {1'b0, y};
      e.r = s[W-1:0];
      e.c = s[W];
      e.v = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]);
    end
    return e;
  endfunction

  // Steps edges (sampled #1 after) until done, returning edges consumed; bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_completion(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_result"}, int'(result), int'(e.r));
      chk({tag, "_cout"}, int'(cout), int'(e.c));
      chk({tag, "_ovf"}, int'(ovf), int'(e.v));
    end
  endtask

  // Full single operation with latency and pulse-width checks.
  task automatic issue(input string tag, input logic o, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = '1; b = '1; op = ~o;
    chk({tag, "_busy_after_accept"}, int'(busy), 1);
    wait_done(n);
    chk({tag, "_latency"}, n, W);
    check_completion(tag);
    @(posedge clk); #1;
    chk({tag, "_done_width"}, int'(done), 0);
    chk({tag, "_busy_clear"}, int'(busy), 0);
  endtask

  vec_t vecs[9];

  initial begin
    int n;
    int acc [4];
    logic [W-1:0] ra, rb;
    logic         ro;
    logic [W-1:0] held;
    vec_t b2b[4];

    vecs[0] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h80, 8'hFF, 8'h7F, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};

    b2b[0] = '{1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0};
    b2b[1] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
    b2b[2] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    b2b[3] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_cout", int'(cout), 0);
    chk("rst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      sbq.push_back('{vecs[i].r, vecs[i].c, vecs[i].v});
      issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b);
    end

    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      ro = 1'($urandom);
      sbq.push_back(model(ro, ra, rb));
      issue($sformatf("rnd%0d", i), ro, ra, rb);
    end

    // start pulses while RUN (edge 3) and DONE (edge 9) must be ignored
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 8'h12; b = 8'h34;
    sbq.push_back(model(1'b0, 8'h12, 8'h34));
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      start = (e == 3 || e == 9);
      op = 1'b1; a = 8'hFF; b = 8'h01;
      @(posedge clk); #1;
      start = 1'b0;
      if (e <= 8) chk($sformatf("ign_busy_e%0d", e), int'(busy), 1);
      if (e == 8) begin
        chk("ign_done", int'(done), 1);
        check_completion("ign");
      end
      if (e >= 9) begin
        chk($sformatf("ign_idle_e%0d", e), int'(busy), 0);
        chk($sformatf("ign_nodone_e%0d", e), int'(done), 0);
      end
    end

    // asynchronous reset during RUN bit 4
    held = result;
    chk("pre_rst_result_nonzero", int'(held != 0), 1);
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 8'h7F; b = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_cout", int'(cout), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    n = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk("mid_rst_no_done", n, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sbq.push_back(model(1'b1, 8'hC3, 8'h3C));
    issue("post_rst", 1'b1, 8'hC3, 8'h3C);

    // start held high: back-to-back operations every W+2 edges
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      op = b2b[k].op; a = b2b[k].a; b = b2b[k].b;
      sbq.push_back('{b2b[k].r, b2b[k].c, b2b[k].v});
      if (k > 0) begin
        @(posedge clk); #1;
      end
      n = 0;
      while (!busy && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      acc[k] = cyc;
      if (k > 0) chk($sformatf("b2b_spacing%0d", k), acc[k] - acc[k-1], W + 2);
      if (k == 3) start = 1'b0;
      wait_done(n);
      chk($sformatf("b2b_latency%0d", k), n, W);
      check_completion($sformatf("b2b%0d", k));
    end
    @(posedge clk); #1;
    chk("b2b_final_idle", int'(busy), 0);
    chk("sb_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected 0", 1);
    $fatal(1, "timeout");
  end

endmodule
